display_mux_scheduler: RTL and testbench

- Time-multiplexes N_DISP seven-segment digits that share one segment decoder.
- Sequences a blank (dead-time) interval and then an on (dwell) interval per digit, round-robin, so adjacent digits do not ghost.
- Takes the place of the free-running divided clock as the display select source; all timing is counted in clk cycles.
- Digit values and timing configuration are double-buffered and take effect only at frame boundaries, so a frame never shows mixed old and new data.

---
 rtl/display_pkg.sv | 8 +
 rtl/display_mux_scheduler_interval_timer.sv | 25 ++
 rtl/display_mux_scheduler.sv | 120 ++++++++++++
 tb/tb_display_mux_scheduler.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types and constants for the multiplexed seven-segment display scheduler.
package display_pkg;
  localparam int          DIGIT_W       = 4;
  localparam logic [31:0] DEFAULT_DWELL = 32'd24000;
  localparam logic [15:0] DEFAULT_BLANK = 16'd240;

  typedef enum logic {S_BLANK, S_ON} disp_state_t;
endpackage

// File: rtl/display_mux_scheduler_interval_timer.sv
// 32-bit up-counter with synchronous clear. The terminal count fires at limit-1.
// A limit of 0 behaves like a limit of 1.
module interval_timer (
  input  logic        clk,
  input  logic        i_rst,
  input  logic        i_clear,
  input  logic [31:0] i_limit,
  output logic        o_tc
);
  logic [31:0] r_count;
  logic [31:0] w_limit_m1;

  assign w_limit_m1 = (i_limit == 32'd0) ? 32'd0 : i_limit - 32'd1;
  assign o_tc       = (r_count == w_limit_m1);

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= 32'd0;
    end else if (i_clear) begin
      r_count <= 32'd0;
    end else begin
      r_count <= r_count + 32'd1;
    end
  end
endmodule

// File: rtl/display_mux_scheduler.sv
// Round-robin blank/dwell scheduler for N_DISP digits that share one decoder.
// Digit data and timing are double-buffered, so they change only at frame wrap.
module display_mux_scheduler
  import display_pkg::*;
#(
  parameter int          N_DISP        = 2,
  parameter logic [31:0] DEFAULT_DWELL = display_pkg::DEFAULT_DWELL,
  parameter logic [15:0] DEFAULT_BLANK = display_pkg::DEFAULT_BLANK
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DIGIT_W*N_DISP-1:0] digits_in,
  input  logic                      digit_load,
  input  logic [31:0]               cfg_dwell,
  input  logic [15:0]               cfg_blank,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  output logic [N_DISP-1:0]         disp_en,
  output logic [3:0]                sel_digit,
  output logic                      frame_tick
);
  localparam int IW = (N_DISP > 1) ? $clog2(N_DISP) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N_DISP - 1);

  // Handshake: a config transfers on an edge where cfg_valid && cfg_ready.
  // cfg_ready stays low while a config is pending. It rises on the frame
  // wrap that makes the pending config active.
  disp_state_t                r_state;
  logic [IW-1:0]              r_idx;
  logic [N_DISP-1:0]          r_disp_en;
  logic [3:0]                 r_sel;
  logic                       r_tick;
  logic                       r_cfg_ready;
  logic [31:0]                r_dwell_act;
  logic [15:0]                r_blank_act;
  logic [31:0]                r_pend_dwell;
  logic [15:0]                r_pend_blank;
  logic [DIGIT_W*N_DISP-1:0]  r_stage;
  logic [DIGIT_W*N_DISP-1:0]  r_shadow;

  logic [31:0]        w_limit;
  logic               w_tc;
  logic               w_wrap;
  logic [N_DISP-1:0]  w_onehot;
  logic [3:0]         w_cur_digit;

  assign w_limit = (r_state == S_BLANK) ? {16'h0000, r_blank_act} : r_dwell_act;
  assign w_wrap  = w_tc && (r_state == S_ON) && (r_idx == LAST_IDX);

  always_comb begin
    w_onehot    = '0;
    w_cur_digit = 4'h0;
    for (int i = 0; i < N_DISP; i++) begin
      w_onehot[i] = (r_idx == IW'(i));
      if (r_idx == IW'(i)) w_cur_digit = r_shadow[i*DIGIT_W +: DIGIT_W];
    end
  end

  interval_timer u_timer (
    .clk     (clk),
    .i_rst   (reset),
    .i_clear (w_tc),
    .i_limit (w_limit),
    .o_tc    (w_tc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_BLANK;
      r_idx        <= '0;
      r_disp_en    <= '0;
      r_sel        <= 4'h0;
      r_tick       <= 1'b0;
      r_cfg_ready  <= 1'b1;
      r_dwell_act  <= DEFAULT_DWELL;
      r_blank_act  <= DEFAULT_BLANK;
      r_pend_dwell <= 32'd0;
      r_pend_blank <= 16'd0;
      r_stage      <= '0;
      r_shadow     <= '0;
    end else begin
      r_tick <= 1'b0;
      if (digit_load) r_stage <= digits_in;

      if (w_tc) begin
        if (r_state == S_BLANK) begin
          r_state   <= S_ON;
          r_disp_en <= w_onehot;
          r_sel     <= w_cur_digit;
        end else begin
          r_state   <= S_BLANK;
          r_disp_en <= '0;
          r_sel     <= 4'h0;
          r_idx     <= (r_idx == LAST_IDX) ? '0 : r_idx + IW'(1);
        end
      end

      if (w_wrap) begin
        r_tick   <= 1'b1;
        r_shadow <= r_stage;
      end

      // A pending config is applied at wrap. A transfer on a wrap edge with no pending config waits for the next wrap.
      if (w_wrap && !r_cfg_ready) begin
        r_dwell_act <= r_pend_dwell;
        r_blank_act <= r_pend_blank;
        r_cfg_ready <= 1'b1;
      end else if (cfg_valid && r_cfg_ready) begin
        r_pend_dwell <= cfg_dwell;
        r_pend_blank <= cfg_blank;
        r_cfg_ready  <= 1'b0;
      end
    end
  end

  assign disp_en    = r_disp_en;
  assign sel_digit  = r_sel;
  assign frame_tick = r_tick;
  assign cfg_ready  = r_cfg_ready;
endmodule

// File: tb/tb_display_mux_scheduler.sv
// Directed bench for display_mux_scheduler, built with N_DISP=2 and the 4/2 default timing.
module tb_display_mux_scheduler;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  digits_in = 8'h00;
  logic        digit_load = 1'b0;
  logic [31:0] cfg_dwell = 32'd0;
  logic [15:0] cfg_blank = 16'd0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [1:0]  disp_en;
  logic [3:0]  sel_digit;
  logic        frame_tick;

  int n_vec = 0;
  int n_err = 0;

  display_mux_scheduler #(
    .N_DISP        (2),
    .DEFAULT_DWELL (32'd4),
    .DEFAULT_BLANK (16'd2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .digits_in  (digits_in),
    .digit_load (digit_load),
    .cfg_dwell  (cfg_dwell),
    .cfg_blank  (cfg_blank),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .disp_en    (disp_en),
    .sel_digit  (sel_digit),
    .frame_tick (frame_tick)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Entered at a negedge sample point. Checks n cycles and returns at the sample point of the next cycle.
  task automatic run(input string tag, input logic [1:0] en, input logic [3:0] sel,
                     input int n, input logic tick);
    for (int i = 0; i < n; i++) begin
      check_vec({tag, ".en"},   32'(disp_en),    32'(en));
      check_vec({tag, ".sel"},  32'(sel_digit),  32'(sel));
      check_vec({tag, ".tick"}, 32'(frame_tick), (i == 0) ? 32'(tick) : 32'd0);
      @(negedge clk);
    end
  endtask

  task automatic check_reset_outs(input string tag);
    check_vec({tag, ".en"},    32'(disp_en),    32'd0);
    check_vec({tag, ".sel"},   32'(sel_digit),  32'd0);
    check_vec({tag, ".tick"},  32'(frame_tick), 32'd0);
    check_vec({tag, ".ready"}, 32'(cfg_ready),  32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 check_reset_outs("rst_hold");
    @(negedge clk);
    reset = 1'b0;

    // T1: defaults of 2 blank / 4 on. Load 3A before the first wrap.
    check_reset_outs("rel_c1");
    digits_in = 8'h3A; digit_load = 1'b1;
    @(negedge clk);
    digit_load = 1'b0;
    run("t1_b0", 2'b00, 4'h0, 1, 1'b0);
    run("t1_on0", 2'b01, 4'h0, 4, 1'b0);
    run("t1_b1", 2'b00, 4'h0, 2, 1'b0);
    run("t1_on1", 2'b10, 4'h0, 4, 1'b0);
    run("t1_f2b0", 2'b00, 4'h0, 2, 1'b1);
    run("t1_f2on0", 2'b01, 4'hA, 4, 1'b0);
    run("t1_f2b1", 2'b00, 4'h0, 2, 1'b0);
    run("t1_f2on1", 2'b10, 4'h3, 3, 1'b0);

    // T2: load 57 on the wrap edge. The next frame keeps 3A, and the frame after shows 7 and 5.
    digits_in = 8'h57; digit_load = 1'b1;
    run("t1_f2on1e", 2'b10, 4'h3, 1, 1'b0);
    digit_load = 1'b0;
    run("t2_f3b0", 2'b00, 4'h0, 2, 1'b1);
    run("t2_f3on0", 2'b01, 4'hA, 4, 1'b0);
    run("t2_f3b1", 2'b00, 4'h0, 2, 1'b0);
    run("t2_f3on1", 2'b10, 4'h3, 4, 1'b0);

    // T3: send dwell=8, blank=1 mid-frame. It takes effect after the wrap.
    run("t2_f4b0", 2'b00, 4'h0, 2, 1'b1);
    run("t2_f4on0", 2'b01, 4'h7, 2, 1'b0);
    cfg_dwell = 32'd8; cfg_blank = 16'd1; cfg_valid = 1'b1;
    run("t3_xfer", 2'b01, 4'h7, 1, 1'b0);
    cfg_valid = 1'b0;
    check_vec("t3_ready_low", 32'(cfg_ready), 32'd0);
    run("t3_f4on0", 2'b01, 4'h7, 1, 1'b0);
    run("t3_f4b1", 2'b00, 4'h0, 2, 1'b0);
    run("t3_f4on1", 2'b10, 4'h5, 4, 1'b0);
    check_vec("t3_ready_tick", 32'(cfg_ready), 32'd1);
    run("t3_f5b0", 2'b00, 4'h0, 1, 1'b1);
    run("t3_f5on0a", 2'b01, 4'h7, 3, 1'b0);

    // T4a: transfer 3/2, then hold cfg_valid with 6/3 through the wrap. The 6/3 request must not transfer.
    cfg_dwell = 32'd3; cfg_blank = 16'd2; cfg_valid = 1'b1;
    run("t4_xfer", 2'b01, 4'h7, 1, 1'b0);
    cfg_dwell = 32'd6; cfg_blank = 16'd3;
    check_vec("t4_ready_low", 32'(cfg_ready), 32'd0);
    run("t3_f5on0b", 2'b01, 4'h7, 4, 1'b0);
    run("t3_f5b1", 2'b00, 4'h0, 1, 1'b0);
    run("t3_f5on1", 2'b10, 4'h5, 8, 1'b0);
    cfg_valid = 1'b0;
    check_vec("t4_ready_tick", 32'(cfg_ready), 32'd1);
    run("t4_f6b0", 2'b00, 4'h0, 2, 1'b1);
    run("t4_f6on0", 2'b01, 4'h7, 3, 1'b0);
    run("t4_f6b1", 2'b00, 4'h0, 2, 1'b0);
    run("t4_f6on1", 2'b10, 4'h5, 2, 1'b0);

    // T4b/T5: transfer 0/0 on the wrap edge. It applies only after the following wrap.
    cfg_dwell = 32'd0; cfg_blank = 16'd0; cfg_valid = 1'b1;
    run("t4_f6on1e", 2'b10, 4'h5, 1, 1'b0);
    cfg_valid = 1'b0;
    check_vec("t4_ready_wrapx", 32'(cfg_ready), 32'd0);
    run("t4_f7b0", 2'b00, 4'h0, 2, 1'b1);
    run("t4_f7on0", 2'b01, 4'h7, 3, 1'b0);
    run("t4_f7b1", 2'b00, 4'h0, 2, 1'b0);
    run("t4_f7on1", 2'b10, 4'h5, 3, 1'b0);
    check_vec("t5_ready_tick", 32'(cfg_ready), 32'd1);
    run("t5_f8b0", 2'b00, 4'h0, 1, 1'b1);
    run("t5_f8on0", 2'b01, 4'h7, 1, 1'b0);
    run("t5_f8b1", 2'b00, 4'h0, 1, 1'b0);
    run("t5_f8on1", 2'b10, 4'h5, 1, 1'b0);
    run("t5_f9b0", 2'b00, 4'h0, 1, 1'b1);

    // T6: with a config pending, assert async reset mid-S_ON between clock edges.
    cfg_dwell = 32'd7; cfg_blank = 16'd7; cfg_valid = 1'b1;
    run("t5_f9on0", 2'b01, 4'h7, 1, 1'b0);
    cfg_valid = 1'b0;
    check_vec("t6_ready_low", 32'(cfg_ready), 32'd0);
    run("t5_f9b1", 2'b00, 4'h0, 1, 1'b0);
    check_vec("t6_pre_en", 32'(disp_en), 32'h2);
    check_vec("t6_pre_sel", 32'(sel_digit), 32'h5);
    #2 reset = 1'b1;
    #1 check_reset_outs("t6_async");
    @(posedge clk);
    #1 check_reset_outs("t6_hold");
    @(negedge clk);
    reset = 1'b0;
    check_reset_outs("t6_rel");
    run("t6_b0", 2'b00, 4'h0, 2, 1'b0);
    run("t6_on0", 2'b01, 4'h0, 4, 1'b0);
    run("t6_b1", 2'b00, 4'h0, 2, 1'b0);
    run("t6_on1", 2'b10, 4'h0, 4, 1'b0);
    run("t6_f2b0", 2'b00, 4'h0, 2, 1'b1);
    run("t6_f2on0", 2'b01, 4'h0, 1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
